// File: rtl/pkg_seq.sv
// Shared types and defaults for the ULM instruction-cycle sequencer.
package pkg_seq;

  // Default width of the retired-instruction counter.
  localparam int SEQ_CNT_W = 32;

  // Instruction-cycle phases; the encoding is also exported on state_dbg.
  typedef enum logic [2:0] {
    SEQ_FETCH  = 3'd0,
    SEQ_DECODE = 3'd1,
    SEQ_EXEC   = 3'd2,
    SEQ_WAIT   = 3'd3,
    SEQ_HALT   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/dev_sequencer.sv
// Instruction-cycle controller: fetch -> decode -> execute, waits for bus/IO
// completions, counts retired instructions and parks in HALT on a halt op.
//
// Handshakes: ifetch_req is a level request that stays high until ifetch_ack is
// seen in the same cycle; that cycle is the transfer (ir_load pulses with it).
// An ack without a request is ignored. bus_start/io_start are one-cycle start
// pulses, and each is answered later by exactly one bus_done/io_done pulse; a
// done pulse with no matching operation outstanding is ignored.
module dev_sequencer
  import pkg_seq::*;
#(
  parameter int CNT_W = SEQ_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             ifetch_req,
  input  logic             ifetch_ack,
  output logic             ir_load,
  output logic             dec_en,
  input  logic             exec_bus,
  input  logic             exec_io,
  input  logic             exec_halt,
  output logic             alu_en,
  output logic             cu_en,
  output logic             bus_start,
  input  logic             bus_done,
  output logic             io_start,
  input  logic             io_done,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_dbg
);

  seq_state_t state, state_d;
  logic       bus_pend, bus_pend_d;
  logic       io_pend, io_pend_d;
  logic       retire;
  // Low for the first cycle after reset so no fetch is requested in that cycle.
  logic       fetch_arm;

  // State register; reset dominates every state including WAIT and HALT.
  always_ff @(posedge clk) begin
    if (rst) state <= SEQ_FETCH;
    else     state <= state_d;
  end

  // Next-state and strobe decode from the registered state.
  always_comb begin
    state_d    = state;
    bus_pend_d = bus_pend;
    io_pend_d  = io_pend;
    retire     = 1'b0;
    ifetch_req = 1'b0;
    ir_load    = 1'b0;
    dec_en     = 1'b0;
    alu_en     = 1'b0;
    cu_en      = 1'b0;
    bus_start  = 1'b0;
    io_start   = 1'b0;
    case (state)
      SEQ_FETCH: begin
        ifetch_req = run & fetch_arm;
        if (ifetch_req && ifetch_ack) begin
          ir_load = 1'b1;
          state_d = SEQ_DECODE;
        end
      end
      SEQ_DECODE: begin
        dec_en  = 1'b1;
        state_d = SEQ_EXEC;
      end
      SEQ_EXEC: begin
        alu_en = 1'b1;
        cu_en  = 1'b1;
        if (exec_halt) begin
          retire  = 1'b1;
          state_d = SEQ_HALT;
        end else begin
          bus_start  = exec_bus;
          io_start   = exec_io;
          bus_pend_d = exec_bus;
          io_pend_d  = exec_io;
          if (exec_bus || exec_io) begin
            state_d = SEQ_WAIT;
          end else begin
            retire  = 1'b1;
            state_d = SEQ_FETCH;
          end
        end
      end
      SEQ_WAIT: begin
        // A done in the same cycle as the last pending bit finishes the wait.
        bus_pend_d = bus_pend & ~bus_done;
        io_pend_d  = io_pend & ~io_done;
        if (!bus_pend_d && !io_pend_d) begin
          retire  = 1'b1;
          state_d = SEQ_FETCH;
        end
      end
      SEQ_HALT: begin
        state_d = SEQ_HALT;
      end
      default: begin
        state_d = SEQ_FETCH;
      end
    endcase
  end

  // Pending bits, fetch arm flag and the wrapping retired counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_pend  <= 1'b0;
      io_pend   <= 1'b0;
      fetch_arm <= 1'b0;
      retired   <= '0;
    end else begin
      bus_pend  <= bus_pend_d;
      io_pend   <= io_pend_d;
      fetch_arm <= 1'b1;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign halted    = (state == SEQ_HALT);
  assign busy      = (state == SEQ_DECODE) || (state == SEQ_EXEC) ||
                     (state == SEQ_WAIT) || ((state == SEQ_FETCH) && ifetch_req);
  assign state_dbg = state;

endmodule

// File: tb/tb_dev_sequencer.sv
// Bench for dev_sequencer: directed scenarios plus a randomized instruction
// stream, with a scoreboard fed by the driver and drained by a monitor.
module tb_dev_sequencer;

  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic ifetch_ack = 1'b0;
  logic exec_bus = 1'b0, exec_io = 1'b0, exec_halt = 1'b0;
  logic bus_done = 1'b0, io_done = 1'b0;
  logic ifetch_req, ir_load, dec_en, alu_en, cu_en, bus_start, io_start;
  logic halted, busy;
  logic [CW-1:0] retired;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  dev_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run),
    .ifetch_req(ifetch_req), .ifetch_ack(ifetch_ack), .ir_load(ir_load),
    .dec_en(dec_en), .exec_bus(exec_bus), .exec_io(exec_io),
    .exec_halt(exec_halt), .alu_en(alu_en), .cu_en(cu_en),
    .bus_start(bus_start), .bus_done(bus_done), .io_start(io_start),
    .io_done(io_done), .halted(halted), .busy(busy), .retired(retired),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  // Strobe vector order: {ir_load, dec_en, alu_en, cu_en, bus_start, io_start}
  logic [5:0]    exp_q[$];
  logic [CW-1:0] exp_ret_q[$];
  int            ret_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle with any strobe pops one expected vector; every
  // change of retired (outside reset) pops one expected count.
  logic [CW-1:0] prev_ret = '0;
  always @(negedge clk) begin : monitor
    logic [5:0] s;
    s = {ir_load, dec_en, alu_en, cu_en, bus_start, io_start};
    if (rst) begin
      prev_ret = retired;
    end else begin
      if (s != 6'd0) begin
        if (exp_q.size() == 0) check("strobe_unexpected", 32'(s), 32'd0);
        else                   check("strobes", 32'(s), 32'(exp_q.pop_front()));
      end
      if (retired != prev_ret) begin
        if (exp_ret_q.size() == 0) check("retire_unexpected", 32'(retired), 32'(prev_ret));
        else                       check("retired", 32'(retired), 32'(exp_ret_q.pop_front()));
        prev_ret = retired;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driver activity happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_retire();
    ret_model = (ret_model + 1) % (1 << CW);
    exp_ret_q.push_back(CW'(ret_model));
  endtask

  task automatic randomize_exec();
    exec_bus  = 1'($urandom_range(0, 1));
    exec_io   = 1'($urandom_range(0, 1));
    exec_halt = 1'($urandom_range(0, 1));
  endtask

  // Waits for a request, acks it after ack_dly cycles, and returns in the
  // EXEC cycle of that instruction.
  task automatic issue(input logic b, input logic io, input logic h,
                       input int ack_dly, output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ifetch_req && n < 60) begin
      step();
      n++;
    end
    check("req_timeout", 32'(ifetch_req), 32'd1);
    if (!ifetch_req) return;
    for (int i = 0; i < ack_dly; i++) step();
    check("req_held", 32'(ifetch_req), 32'd1);
    exec_bus   = b;
    exec_io    = io;
    exec_halt  = h;
    ifetch_ack = 1'b1;
    exp_q.push_back(6'b100000);
    exp_q.push_back(6'b010000);
    exp_q.push_back({2'b00, 2'b11, b & ~h, io & ~h});
    step();
    ifetch_ack = 1'b0;
    step();
    ok = 1'b1;
  endtask

  // One full instruction. bd/id: cycles after the start pulse at which the
  // matching done pulse is driven (only used when that unit is in use).
  task automatic do_instr(input logic b, input logic io, input logic h,
                          input int ack_dly, input int bd, input int id);
    logic ok;
    int   last;
    push_retire();
    issue(b, io, h, ack_dly, ok);
    if (!ok) return;
    if (h) begin
      step();
      check("halted_set", 32'(halted), 32'd1);
      check("halt_no_req", 32'(ifetch_req), 32'd0);
    end else if (!b && !io) begin
      step();
      randomize_exec();
      check("alu_next_req", 32'(ifetch_req), 32'd1);
    end else begin
      last = 0;
      if (b && bd > last) last = bd;
      if (io && id > last) last = id;
      for (int c = 1; c <= last; c++) begin
        step();
        randomize_exec();
        bus_done = b  ? (c == bd) : ($urandom_range(0, 3) == 0);
        io_done  = io ? (c == id) : ($urandom_range(0, 3) == 0);
        check("wait_no_req", 32'(ifetch_req), 32'd0);
        check("wait_busy", 32'(busy), 32'd1);
      end
      step();
      bus_done = 1'b0;
      io_done  = 1'b0;
      check("wait_exit_req", 32'(ifetch_req), 32'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    ret_model = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic ok;
    int   n;
    run = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("rst_req", 32'(ifetch_req), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_strobes", 32'({ir_load, dec_en, alu_en, cu_en, bus_start, io_start}), 32'd0);

    // ALU-only stream, ack one cycle after each request.
    for (int i = 0; i < 4; i++) do_instr(1'b0, 1'b0, 1'b0, 1, 0, 0);
    check("retired_after_4", 32'(retired), 32'd4);

    // Bus op with a done 5 cycles after the start pulse.
    do_instr(1'b1, 1'b0, 1'b0, 1, 5, 0);
    check("retired_after_bus", 32'(retired), 32'd5);

    // Bus and IO: IO first then bus two cycles later; then both together.
    do_instr(1'b1, 1'b1, 1'b0, 1, 3, 1);
    do_instr(1'b1, 1'b1, 1'b0, 0, 4, 4);

    // Randomized stream.
    for (int i = 0; i < 30; i++)
      do_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
               $urandom_range(0, 2), $urandom_range(1, 6), $urandom_range(1, 6));

    // run drops while a request is outstanding: late ack must be ignored.
    n = 0;
    while (!ifetch_req && n < 60) begin
      step();
      n++;
    end
    check("pre_drop_req", 32'(ifetch_req), 32'd1);
    run = 1'b0;
    #1;
    check("drop_req", 32'(ifetch_req), 32'd0);
    step();
    ifetch_ack = 1'b1;
    #1;
    check("late_ack_no_load", 32'(ir_load), 32'd0);
    check("parked_busy", 32'(busy), 32'd0);
    step();
    ifetch_ack = 1'b0;
    repeat (3) step();
    check("parked_req", 32'(ifetch_req), 32'd0);
    run = 1'b1;
    do_instr(1'b0, 1'b0, 1'b0, 1, 0, 0);

    // Reset in the middle of WAIT; a later bus_done must be ignored.
    issue(1'b1, 1'b0, 1'b0, 0, ok);
    step();
    step();
    check("midwait_busy", 32'(busy), 32'd1);
    do_reset();
    check("midwait_rst_retired", 32'(retired), 32'd0);
    check("midwait_rst_busy", 32'(busy), 32'd0);
    bus_done = 1'b1;
    step();
    bus_done = 1'b0;
    do_instr(1'b0, 1'b0, 1'b0, 0, 0, 0);
    do_instr(1'b1, 1'b0, 1'b0, 0, 2, 0);
    check("after_midwait_retired", 32'(retired), 32'd2);

    // Halt: sticky, no fetch requests, acks ignored, until reset.
    do_instr(1'b0, 1'b0, 1'b1, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      ifetch_ack = 1'($urandom_range(0, 1));
      #1;
      check("halt_sticky", 32'(halted), 32'd1);
      check("halt_req_low", 32'(ifetch_req), 32'd0);
      check("halt_busy_low", 32'(busy), 32'd0);
    end
    ifetch_ack = 1'b0;
    do_reset();
    check("halt_cleared", 32'(halted), 32'd0);

    // Counter wrap with a 4-bit counter: 17 instructions leave it at 1.
    for (int i = 0; i < 17; i++) do_instr(1'b0, 1'b0, 1'b0, $urandom_range(0, 2), 0, 0);
    check("wrap_retired", 32'(retired), 32'd1);

    repeat (3) step();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("exp_ret_q_empty", 32'(exp_ret_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time bound on the whole run.
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
